prio_arbiter_rr: RTL

- Parametrised, registered successor to the 8-input combinational priority encoder.
- Arbitrates N level-sensitive request lines and presents the winner as a binary index and a one-hot vector.
- Grant is held under a valid/ready handshake; selectable at run time between fixed priority (req[0] highest) and round-robin.
- Sits between request sources and a shared consumer (bus, ALU port, output mux).

---
 rtl/prio_arbiter_rr_pkg.sv | 17 +
 rtl/prio_find_rr.sv | 37 +++
 rtl/prio_arbiter_rr.sv | 88 ++++++++
 3 files changed

// File: rtl/prio_arbiter_rr_pkg.sv
// Shared types and helpers for the registered priority / round-robin arbiter.
package prio_arbiter_rr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Minimum index width for n requesters, never below one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prio_find_rr.sv
// Combinational winner search: lowest set bit (fixed) or first set bit from start, wrapping at N (rr).
module prio_find_rr
  import prio_arbiter_rr_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             mode_rr,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  int p;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    p      = 0;
    for (int k = 0; k < N; k++) begin
      if (!found) begin
        // start is always < N, so a single subtraction wraps correctly.
        p = mode_rr ? (int'(start) + k) : k;
        if (p >= N) p = p - N;
        if (req[p]) begin
          found     = 1'b1;
          idx       = IDX_W'(p);
          onehot[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter, fixed priority or round-robin, grant held under valid/ready.
// One-cycle request-to-grant latency; back-to-back grants on accept when others still request.
module prio_arbiter_rr
  import prio_arbiter_rr_pkg::*;
#(
  parameter int N = 8,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode_rr,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot
);

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx, ptr_inc, start;
  logic [IDX_W-1:0] idx_nx, find_idx;
  logic [N-1:0]     oh_nx, find_req, find_oh;
  logic             valid_nx, find_found;

  // Pointer successor wraps at N, not at the power of two above it.
  assign ptr_inc  = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign find_req = (state == IDLE) ? req : (req & ~gnt_onehot);
  assign start    = (state == IDLE) ? ptr : ptr_inc;

  prio_find_rr #(.N(N)) u_find (
    .req     (find_req),
    .start   (start),
    .mode_rr (mode_rr),
    .found   (find_found),
    .idx     (find_idx),
    .onehot  (find_oh)
  );

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    valid_nx = gnt_valid;
    idx_nx   = gnt_idx;
    oh_nx    = gnt_onehot;
    case (state)
      IDLE: begin
        if (find_found) begin
          state_nx = GRANT;
          valid_nx = 1'b1;
          idx_nx   = find_idx;
          oh_nx    = find_oh;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          ptr_nx = ptr_inc;
          if (find_found) begin
            idx_nx = find_idx;
            oh_nx  = find_oh;
          end else begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            idx_nx   = '0;
            oh_nx    = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      gnt_valid  <= valid_nx;
      gnt_idx    <= idx_nx;
      gnt_onehot <= oh_nx;
    end
  end

endmodule
